// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of vga_timing_gen: run control in, pixel position,
// qualifiers and syncs out. The generator drives through the master modport,
// the display drivers consume through the slave modport.
`timescale 1ns/1ps
interface vga_timing_gen_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic           enable;
  logic [X_W-1:0] XPos;
  logic [Y_W-1:0] YPos;
  logic           Valid;
  logic           line_start;
  logic           frame_start;
  logic           hsync;
  logic           vsync;
  logic [7:0]     frame_count;

  modport master (
    input  enable,
    output XPos, YPos, Valid, line_start, frame_start, hsync, vsync, frame_count
  );

  modport slave (
    output enable,
    input  XPos, YPos, Valid, line_start, frame_start, hsync, vsync, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster counters with a same-cycle decode of
// pixel position / active video / line and frame pulses, plus hsync/vsync
// delayed by SYNC_DELAY cycles to line up with registered RGB pipelines.
// Optional feature macro: VGA_TIMING_FRAME_COUNT_EN enables the 8-bit
// completed-frame counter; otherwise frame_count is tied to zero.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int H_ACTIVE   = 1024,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 136,
  parameter int H_BP       = 160,
  parameter int V_ACTIVE   = 768,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 6,
  parameter int V_BP       = 29,
  parameter bit SYNC_POL   = 1'b0,
  parameter int SYNC_DELAY = 2
) (
  input logic              clk,
  input logic              reset_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X_W     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END   = 11'(H_ACTIVE);
  localparam logic [9:0]  V_ACT_END   = 10'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_SYNC_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt_reg;
  logic [9:0]  v_cnt_reg;
  logic        h_wrap;
  logic        v_wrap;
  logic        run;
  logic        active;
  logic        hs_raw;
  logic        vs_raw;

  assign h_wrap = (h_cnt_reg == H_LAST);
  assign v_wrap = (v_cnt_reg == V_LAST);

  // Raster counters: parked at (0,0) while idle so a restart always opens a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (!vga.enable) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_wrap) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= v_wrap ? '0 : v_cnt_reg + 10'd1;
    end else begin
      h_cnt_reg <= h_cnt_reg + 11'd1;
    end
  end

  // Region decode; reset and idle both force qualifiers off and raw syncs inactive.
  always_comb begin
    run    = reset_n & vga.enable;
    active = run && (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
    hs_raw = (run && (h_cnt_reg >= H_SYNC_BEG) && (h_cnt_reg < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vs_raw = (run && (v_cnt_reg >= V_SYNC_BEG) && (v_cnt_reg < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
  end

  assign vga.Valid       = active;
  assign vga.XPos        = active ? h_cnt_reg[X_W-1:0] : '0;
  assign vga.YPos        = active ? v_cnt_reg[Y_W-1:0] : '0;
  assign vga.line_start  = run && (h_cnt_reg == 11'd0);
  assign vga.frame_start = run && (h_cnt_reg == 11'd0) && (v_cnt_reg == 10'd0);

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign vga.hsync = hs_raw;
      assign vga.vsync = vs_raw;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe_reg;
      logic [SYNC_DELAY-1:0] vs_pipe_reg;
      logic [SYNC_DELAY:0]   hs_next;
      logic [SYNC_DELAY:0]   vs_next;

      // Top bit of *_next is the oldest stage and feeds the output pin.
      assign hs_next   = {hs_pipe_reg, hs_raw};
      assign vs_next   = {vs_pipe_reg, vs_raw};
      assign vga.hsync = hs_next[SYNC_DELAY];
      assign vga.vsync = vs_next[SYNC_DELAY];

      // Sync shift register keeps running while idle so it drains to inactive.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          hs_pipe_reg <= {SYNC_DELAY{~SYNC_POL}};
          vs_pipe_reg <= {SYNC_DELAY{~SYNC_POL}};
        end else begin
          hs_pipe_reg <= hs_next[SYNC_DELAY-1:0];
          vs_pipe_reg <= vs_next[SYNC_DELAY-1:0];
        end
      end
    end
  endgenerate

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [7:0] frame_count_reg;

  // Count frames completed by the (last,last) -> (0,0) wrap; holds while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_reg <= 8'd0;
    end else if (vga.enable && h_wrap && v_wrap) begin
      frame_count_reg <= frame_count_reg + 8'd1;
    end
  end

  assign vga.frame_count = frame_count_reg;
`else
  assign vga.frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using the small 14x7 raster. A behavioural model
// pushes the expected outputs for every driven cycle into a queue; each
// scenario task pops and compares on the falling edge. A second instance
// with SYNC_DELAY=0 shares all stimulus.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.X_W(3), .Y_W(2)) bus ();
  vga_timing_gen_if #(.X_W(3), .Y_W(2)) bus0 ();

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .SYNC_DELAY(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vga(bus)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .SYNC_DELAY(0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .vga(bus0)
  );

  typedef struct packed {
    logic       valid;
    logic [2:0] x;
    logic [1:0] y;
    logic       ls;
    logic       fs;
    logic       hs;
    logic       vs;
    logic       hs0;
    logic       vs0;
    logic [7:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Model state
  int         mh, mv;
  logic       m_hs1, m_hs2, m_vs1, m_vs2;
  logic [7:0] mfc;
  logic       cur_rst = 1'b0;
  logic       cur_en = 1'b0;

  function automatic logic raw_h(int h, logic run);
    return (run && h >= 10 && h < 12) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic raw_v(int v, logic run);
    return (run && v == 5) ? 1'b0 : 1'b1;
  endfunction

  function automatic exp_t model_now();
    exp_t e;
    logic run;
    logic act;
    run     = cur_rst && cur_en;
    act     = run && mh < 8 && mv < 4;
    e.valid = act;
    e.x     = act ? 3'(mh) : 3'd0;
    e.y     = act ? 2'(mv) : 2'd0;
    e.ls    = run && mh == 0;
    e.fs    = run && mh == 0 && mv == 0;
    e.hs    = m_hs2;
    e.vs    = m_vs2;
    e.hs0   = raw_h(mh, run);
    e.vs0   = raw_v(mv, run);
    e.fc    = mfc;
    return e;
  endfunction

  function automatic exp_t get_act();
    exp_t a;
    a = {bus.Valid, bus.XPos, bus.YPos, bus.line_start, bus.frame_start,
         bus.hsync, bus.vsync, bus0.hsync, bus0.vsync, bus.frame_count};
    return a;
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0;
    m_hs1 = 1'b1; m_hs2 = 1'b1; m_vs1 = 1'b1; m_vs2 = 1'b1;
    mfc = 8'd0;
  endtask

  task automatic model_clock();
    logic run;
    if (!cur_rst) begin
      model_reset();
    end else begin
      run   = cur_en;
      m_hs2 = m_hs1; m_hs1 = raw_h(mh, run);
      m_vs2 = m_vs1; m_vs1 = raw_v(mv, run);
`ifdef VGA_TIMING_FRAME_COUNT_EN
      if (cur_en && mh == 13 && mv == 6) mfc = mfc + 8'd1;
`endif
      if (!cur_en) begin
        mh = 0; mv = 0;
      end else if (mh == 13) begin
        mh = 0;
        mv = (mv == 6) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
  endtask

  // Advance one cycle: apply inputs just after the rising edge, queue the
  // expected outputs, then wait for the falling edge to sample.
  task automatic drive_cycle(input logic r, input logic e);
    @(posedge clk);
    model_clock();
    #1;
    cur_rst = r; cur_en = e;
    reset_n = r; bus.enable = e; bus0.enable = e;
    if (!r) model_reset();
    exp_q.push_back(model_now());
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e, a;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b1);
      e = exp_q.pop_front();
      a = get_act();
      tests_run++;
      if (a !== e || a !== 20'b0_000_00_0_0_1_1_1_1_00000000) begin
        tests_failed++;
        $display("FAIL reset_state cyc=%0d got=%h want=%h", i, a, e);
      end else $display("[TB] reset cyc=%0d out=%h", i, a);
    end
  endtask

  task automatic test_raster_walk();
    exp_t e, a;
    logic hs_want, vs_want;
    for (int n = 0; n < 200; n++) begin
      drive_cycle(1'b1, 1'b1);
      e = exp_q.pop_front();
      a = get_act();
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL raster n=%0d got=%h want=%h", n, a, e);
      end else $display("[TB] raster n=%0d out=%h", n, a);
      // Independent placement checks straight from the raster geometry
      hs_want = !(n >= 2 && ((n - 2) % 14) >= 10 && ((n - 2) % 14) <= 11);
      vs_want = !(n >= 2 && (((n - 2) / 14) % 7) == 5);
      tests_run++;
      if (bus.hsync !== hs_want || bus.vsync !== vs_want) begin
        tests_failed++;
        $display("FAIL sync_place n=%0d got=%b%b want=%b%b", n, bus.hsync, bus.vsync, hs_want, vs_want);
      end
      if (n % 98 == 0) begin
        tests_run++;
        if (bus.frame_start !== 1'b1 || bus.Valid !== 1'b1 || bus.XPos !== 3'd0 || bus.YPos !== 2'd0) begin
          tests_failed++;
          $display("FAIL frame_start n=%0d got fs=%b v=%b want fs=1 v=1", n, bus.frame_start, bus.Valid);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    exp_t e, a;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b1);
      void'(exp_q.pop_front());
    end
    for (int n = 0; n < 40; n++) begin
      if (n == 33 || n == 34) drive_cycle(1'b0, 1'b1);
      else drive_cycle(1'b1, 1'b1);
      e = exp_q.pop_front();
      a = get_act();
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL reset_mid n=%0d got=%h want=%h", n, a, e);
      end else $display("[TB] reset_mid n=%0d out=%h", n, a);
      if (n == 33) begin
        tests_run++;
        if (bus.Valid !== 1'b0 || bus.hsync !== 1'b1 || bus.vsync !== 1'b1 ||
            bus.XPos !== 3'd0 || bus.YPos !== 2'd0) begin
          tests_failed++;
          $display("FAIL reset_async got=%h want valid=0 syncs=1 pos=0", a);
        end
      end
      if (n == 35) begin
        tests_run++;
        if (bus.frame_start !== 1'b1 || bus.Valid !== 1'b1 || bus.XPos !== 3'd0 || bus.YPos !== 2'd0) begin
          tests_failed++;
          $display("FAIL reset_restart got=%h want fs=1 valid=1 pos=0", a);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    exp_t e, a;
    drive_cycle(1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int n = 0; n < 140; n++) begin
      if (n >= 17 && n < 37) drive_cycle(1'b1, 1'b0);
      else drive_cycle(1'b1, 1'b1);
      e = exp_q.pop_front();
      a = get_act();
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL enable_drop n=%0d got=%h want=%h", n, a, e);
      end else $display("[TB] enable_drop n=%0d out=%h", n, a);
      if (n >= 17 && n < 37) begin
        tests_run++;
        if (bus.Valid !== 1'b0 || bus.frame_start !== 1'b0 || bus.line_start !== 1'b0 ||
            (n >= 19 && (bus.hsync !== 1'b1 || bus.vsync !== 1'b1))) begin
          tests_failed++;
          $display("FAIL idle_outputs n=%0d got=%h want valid=0 pulses=0 syncs=1", n, a);
        end
      end
      if (n == 37) begin
        tests_run++;
        if (bus.frame_start !== 1'b1 || bus.Valid !== 1'b1 || bus.XPos !== 3'd0 || bus.YPos !== 2'd0) begin
          tests_failed++;
          $display("FAIL reenable got=%h want fs=1 valid=1 pos=0", a);
        end
      end
    end
  endtask

  task automatic test_zero_delay();
    logic hs_want;
    drive_cycle(1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int n = 0; n < 42; n++) begin
      drive_cycle(1'b1, 1'b1);
      void'(exp_q.pop_front());
      hs_want = !((n % 14) == 10 || (n % 14) == 11);
      tests_run++;
      if (bus0.hsync !== hs_want) begin
        tests_failed++;
        $display("FAIL zero_delay n=%0d got=%b want=%b", n, bus0.hsync, hs_want);
      end else $display("[TB] zero_delay n=%0d hsync=%b", n, bus0.hsync);
    end
  endtask

  task automatic test_frame_count();
    exp_t e, a;
    logic [7:0] fc_want;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    fc_want = 8'd1;
`else
    fc_want = 8'd0;
`endif
    drive_cycle(1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int n = 0; n <= 257 * 98; n++) begin
      drive_cycle(1'b1, 1'b1);
      e = exp_q.pop_front();
      a = get_act();
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL frame_run n=%0d got=%h want=%h", n, a, e);
      end else if (n % 98 == 0) begin
        $display("[TB] frame n=%0d frame_count=%0d", n, bus.frame_count);
      end
      if (n == 98 || n == 257 * 98) begin
        tests_run++;
        if (bus.frame_count !== fc_want) begin
          tests_failed++;
          $display("FAIL frame_count n=%0d got=%0d want=%0d", n, bus.frame_count, fc_want);
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bus.enable  = 1'b1;
    bus0.enable = 1'b1;
    model_reset();
    test_reset();
    test_raster_walk();
    test_reset_mid_frame();
    test_enable_drop();
    test_zero_delay();
    test_frame_count();
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates the raster timing that drives the VGA/DVI output path.
- Free-running horizontal and vertical counters produce the pixel position (`XPos`, `YPos`) and the active-video qualifier (`Valid`) consumed by the display drivers.
- Also produces `hsync`/`vsync`, each delayed by a configurable number of cycles so they stay aligned with the drivers' registered RGB pipeline.
- Sits between the pixel clock domain root and every `*_vga_driver` instance.

## Interface

Parameters:
- `H_ACTIVE`, 1024: visible pixels per line.
- `H_FP`, 24: horizontal front porch, in cycles.
- `H_SYNC`, 136: hsync pulse width, in cycles.
- `H_BP`, 160: horizontal back porch, in cycles.
- `V_ACTIVE`, 768: visible lines per frame.
- `V_FP`, 3: vertical front porch, in lines.
- `V_SYNC`, 6: vsync pulse width, in lines.
- `V_BP`, 29: vertical back porch, in lines.
- `SYNC_POL`, 0: asserted level of `hsync`/`vsync` (0 = active-low).
- `SYNC_DELAY`, 2: pipeline stages applied to `hsync`/`vsync`. Legal range 0..7.

Ports:
- `clk` input 1: pixel clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `enable` input 1: run raster; when low, the generator idles.
- `XPos` output `log2NUM_COLS`: horizontal pixel index; 0 outside active video.
- `YPos` output `log2NUM_ROWS`: vertical line index; 0 outside active video.
- `Valid` output 1: current (`XPos`, `YPos`) is a visible pixel.
- `line_start` output 1: one-cycle pulse at `h_cnt == 0`.
- `frame_start` output 1: one-cycle pulse at `h_cnt == 0 && v_cnt == 0`.
- `hsync` output 1: horizontal sync, delayed `SYNC_DELAY` cycles.
- `vsync` output 1: vertical sync, delayed `SYNC_DELAY` cycles.
- `frame_count` output 8: completed-frame counter (see Configuration).

## Operation

Counters:
- `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` (1344 by default).
- `V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP` (806 by default).
- `h_cnt` is 11 bits and `v_cnt` is 10 bits. Both are internal registers sized to hold `H_TOTAL-1` and `V_TOTAL-1`.
- While `enable` is high, `h_cnt` increments every cycle.
  - At `H_TOTAL-1` it wraps to 0 and `v_cnt` increments.
  - At `v_cnt == V_TOTAL-1` together with the h wrap, `v_cnt` wraps to 0.

Region decode (evaluated on the current counter values):
- Active: `h_cnt < H_ACTIVE && v_cnt < V_ACTIVE`. During active, `Valid=1`, `XPos=h_cnt`, `YPos=v_cnt` (truncated to port width).
- Otherwise: `Valid=0`, `XPos=0`, `YPos=0`.
- Raw hsync is asserted (`SYNC_POL`) for `H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC`; otherwise it is `~SYNC_POL`.
- Raw vsync is asserted for `V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC`, for the whole line including horizontal blanking.

Sync delay line:
- Raw hsync and vsync each pass through a `SYNC_DELAY`-deep shift register clocked every cycle.
- With `SYNC_DELAY=0` the raw values drive the outputs directly.

`enable`:
- While `enable` is low, both counters are held at 0, and `Valid`, `line_start` and `frame_start` are 0.
- The raw syncs are driven inactive; the delay line keeps shifting, so it drains to inactive.
- When `enable` is deasserted mid-frame, the counters are 0 on the next cycle. No partial-frame completion.
- When `enable` rises, the first enabled cycle presents `h_cnt=0`, `v_cnt=0`, `Valid=1` and `frame_start=1`.

## Timing

- `Valid`, `XPos`, `YPos`, `line_start` and `frame_start` are valid in the same cycle as the counter state they describe. They are a pure decode of registered counters, with no extra latency.
- `hsync`/`vsync` lag that decode by exactly `SYNC_DELAY` cycles.
- Reset values:
  - `h_cnt=0`, `v_cnt=0`.
  - `XPos=0`, `YPos=0`, `Valid=0`, `line_start=0`, `frame_start=0`, `frame_count=0`.
  - `hsync=vsync=~SYNC_POL`; every delay stage resets to `~SYNC_POL`.
  - While `reset_n` is low, all pulse and qualifier outputs are forced to 0, irrespective of the counters.
- First cycle after `reset_n` deasserts with `enable=1`: `Valid=1`, `XPos=0`, `YPos=0`, `frame_start=1`.
- Reset asserted mid-frame: all outputs take their reset values asynchronously. Restart always begins at (0,0).
- Simultaneous h wrap and v wrap: `frame_start` and `line_start` both pulse on the following cycle (counters 0,0).

## Configuration

- Macro: `VGA_TIMING_FRAME_COUNT_EN`.
- Defined: `frame_count` increments by 1, mod 256, on the cycle the counters wrap from (`H_TOTAL-1`, `V_TOTAL-1`) to (0,0). It holds while `enable` is low and resets to 0.
- Undefined: the counter logic is absent and `frame_count` is tied to 8'd0.

## Test plan

All scenarios use small parameters: `H_ACTIVE=8`, `H_FP=2`, `H_SYNC=2`, `H_BP=2` (`H_TOTAL=14`); `V_ACTIVE=4`, `V_FP=1`, `V_SYNC=1`, `V_BP=1` (`V_TOTAL=7`); `SYNC_DELAY=2`; `SYNC_POL=0`.

- **Raster walk.** Release reset with `enable=1`.
  - `Valid` is high for cycles 0..7 of each of lines 0..3, with `XPos=0..7` and `YPos` equal to the line number.
  - `Valid` is low for lines 4..6.
  - `frame_start` recurs every 98 cycles.
- **Sync placement.**
  - `hsync` is low on cycles 12..13 of every line, i.e. raw cycles 10..11 plus 2 delay.
  - `vsync` is low for all 14 cycles of line 5, shifted by 2 cycles.
  - Both are high everywhere else.
- **Reset mid-frame.** Assert `reset_n=0` at line 2, cycle 5.
  - Immediately: `Valid=0`, `hsync=vsync=1`, `XPos=YPos=0`.
  - On release: `frame_start=1` and (0,0) in the first cycle.
- **Enable drop.** Drop `enable` at line 1, cycle 3 for 20 cycles.
  - During the drop: `Valid=0`; syncs high within 2 cycles.
  - On re-enable: the first cycle is (0,0) with `frame_start=1`.
- **Frame counter.** With `VGA_TIMING_FRAME_COUNT_EN` defined, run 257 frames: `frame_count` reads 1 after frame 1 and 1 again after frame 257 (wrap). With the macro undefined, `frame_count` stays 0.
- **Zero delay.** With `SYNC_DELAY=0`, `hsync` is low on exactly cycles 10..11 of each line.
